// File: rtl/ghost_scheduler.sv
// Per-frame ghost sequencer: time-shares the maze wall lookup across the four ghosts,
// issues step enables, and owns the scatter/chase/frightened mode timers.
module ghost_scheduler #(
    parameter int unsigned SCATTER_LONG  = 420,
    parameter int unsigned SCATTER_SHORT = 300,
    parameter int unsigned CHASE_TICKS   = 1200,
    parameter int unsigned FRIGHT_TICKS  = 360
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        powerPellet,
    input  logic [3:0]  ghostEnable,
    input  logic [3:0]  wallBits,
    output logic        qReq,
    output logic [1:0]  qSel,
    output logic [15:0] canMoveAll,
    output logic [3:0]  ghostStep,
    output logic [1:0]  mode,
    output logic        modeFlip,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, QUERY, CAPTURE, STEP} state_t;

    localparam logic [1:0]  MODE_CHASE  = 2'b01;
    localparam logic [1:0]  MODE_FRIGHT = 2'b10;
    localparam logic [10:0] LEN_SL = SCATTER_LONG[10:0];
    localparam logic [10:0] LEN_SS = SCATTER_SHORT[10:0];
    localparam logic [10:0] LEN_CT = CHASE_TICKS[10:0];
    localparam logic [10:0] LEN_FT = FRIGHT_TICKS[10:0];

    state_t      state;
    logic [1:0]  gIdx;
    logic [3:0]  stepMask;
    logic [2:0]  phase;
    logic [10:0] phaseTimer;
    logic [10:0] frightTimer;
    logic        halfToggle;

    logic        accept;
    logic        frightened;
    logic [10:0] phaseLen;
    logic [2:0]  phaseNext;
    logic [10:0] phaseTimerNext;
    logic [10:0] frightNext;
    logic        toggleNext;
    logic [3:0]  maskNext;
    logic [1:0]  modeNext;
    logic        flipNext;

    assign accept     = tick && (state == IDLE);
    assign frightened = (frightTimer != 11'd0);

    always_comb begin
        phaseLen = LEN_CT;
        case (phase)
            3'd0, 3'd2: phaseLen = LEN_SL;
            3'd4, 3'd6: phaseLen = LEN_SS;
            default:    phaseLen = LEN_CT;
        endcase
    end

    // A pellet counts as (re)entry even alongside a tick: the tick's sequence is a half-step with mask 0.
    always_comb begin
        phaseNext      = phase;
        phaseTimerNext = phaseTimer;
        frightNext     = frightTimer;
        toggleNext     = halfToggle;
        maskNext       = 4'hF;
        if (accept && !frightened) begin
            if (phase == 3'd7) begin
                if (phaseTimer != 11'h7FF)
                    phaseTimerNext = phaseTimer + 11'd1;
            end else if (({1'b0, phaseTimer} + 12'd1) >= {1'b0, phaseLen}) begin
                phaseTimerNext = 11'd0;
                phaseNext      = phase + 3'd1;
            end else begin
                phaseTimerNext = phaseTimer + 11'd1;
            end
        end
        if (powerPellet) begin
            frightNext = LEN_FT;
            toggleNext = 1'b0;
            maskNext   = 4'h0;
        end else if (accept && frightened) begin
            frightNext = (frightTimer != 11'd0) ? frightTimer - 11'd1 : 11'd0;
            toggleNext = ~halfToggle;
            maskNext   = toggleNext ? 4'hF : 4'h0;
        end
        modeNext = (frightNext != 11'd0) ? MODE_FRIGHT : {1'b0, phaseNext[0]};
        flipNext = powerPellet ||
                   ((mode != MODE_FRIGHT) && (modeNext != MODE_FRIGHT) && (modeNext != mode));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= 3'd0;
            phaseTimer  <= 11'd0;
            frightTimer <= 11'd0;
            halfToggle  <= 1'b0;
            stepMask    <= 4'h0;
            mode        <= 2'b00;
            modeFlip    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            phase       <= phaseNext;
            phaseTimer  <= phaseTimerNext;
            frightTimer <= frightNext;
            halfToggle  <= toggleNext;
            mode        <= modeNext;
            modeFlip    <= flipNext;
            if (accept)
                stepMask <= maskNext;
            if (tick && (state != IDLE))
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gIdx       <= 2'd0;
            qReq       <= 1'b0;
            qSel       <= 2'd0;
            canMoveAll <= 16'h0000;
            ghostStep  <= 4'h0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ghostStep <= 4'h0;
                    if (tick) begin
                        state <= QUERY;
                        gIdx  <= 2'd0;
                        qReq  <= 1'b1;
                        qSel  <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                QUERY: begin
                    qReq  <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    canMoveAll[{gIdx, 2'b00} +: 4] <= wallBits;
                    if (gIdx == 2'd3) begin
                        ghostStep <= ghostEnable & stepMask;
                        state     <= STEP;
                    end else begin
                        gIdx  <= gIdx + 2'd1;
                        qSel  <= gIdx + 2'd1;
                        qReq  <= 1'b1;
                        state <= QUERY;
                    end
                end
                STEP: begin
                    ghostStep <= 4'h0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_scheduler.sv
// Bench for ghost_scheduler: directed scenarios plus random traffic, checked every cycle
// against a sequence-position / tick-count model of the scheduler.
module tb_ghost_scheduler;

    localparam int SL = 3;
    localparam int SS = 2;
    localparam int CT = 4;
    localparam int FT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        powerPellet = 1'b0;
    logic [3:0]  ghostEnable = 4'hF;
    logic [3:0]  wallBits = 4'h0;
    logic        qReq;
    logic [1:0]  qSel;
    logic [15:0] canMoveAll;
    logic [3:0]  ghostStep;
    logic [1:0]  mode;
    logic        modeFlip;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    ghost_scheduler #(
        .SCATTER_LONG(SL), .SCATTER_SHORT(SS), .CHASE_TICKS(CT), .FRIGHT_TICKS(FT)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .powerPellet(powerPellet),
        .ghostEnable(ghostEnable), .wallBits(wallBits), .qReq(qReq), .qSel(qSel),
        .canMoveAll(canMoveAll), .ghostStep(ghostStep), .mode(mode), .modeFlip(modeFlip),
        .busy(busy), .overrun(overrun)
    );

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;
    logic [3:0] curEn = 4'hF;

    // Model: mPos counts cycles into a sequence (0 = idle, 1..9 = busy), timers are plain tick counts.
    int mPos, mPhase, mPTimer, mFright;
    bit mTog;
    logic [3:0]  mMask;
    logic        expQReq, expFlip, expBusy, expOverrun;
    logic [1:0]  expQSel, expMode;
    logic [15:0] expCan;
    logic [3:0]  expStep;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phaseLen(input int p);
        case (p)
            0, 2:    return SL;
            4, 6:    return SS;
            7:       return 1 << 30;
            default: return CT;
        endcase
    endfunction

    task automatic modelReset();
        mPos = 0; mPhase = 0; mPTimer = 0; mFright = 0; mTog = 0; mMask = 4'h0;
        expQReq = 0; expQSel = 0; expCan = 16'h0; expStep = 4'h0;
        expMode = 2'b00; expFlip = 0; expBusy = 0; expOverrun = 0;
    endtask

    task automatic modelStep(input logic rst, input logic t, input logic p,
                             input logic [3:0] en, input logic [3:0] w);
        int newPos, oldMode, newMode;
        bit acc, frBefore;
        if (rst) begin
            modelReset();
        end else begin
            expStep = (mPos == 8) ? (en & mMask) : 4'h0;
            if (mPos >= 2 && mPos <= 8 && (mPos % 2) == 0)
                expCan[(mPos / 2 - 1) * 4 +: 4] = w;
            acc = t && (mPos == 0);
            if (t && mPos != 0) expOverrun = 1'b1;
            newPos = (mPos == 0) ? (t ? 1 : 0) : ((mPos == 9) ? 0 : mPos + 1);

            frBefore = (mFright > 0);
            oldMode  = int'(expMode);
            if (acc && !frBefore) begin
                if (mPhase == 7) begin
                    if (mPTimer < 2047) mPTimer++;
                end else begin
                    mPTimer++;
                    if (mPTimer >= phaseLen(mPhase)) begin
                        mPTimer = 0;
                        mPhase++;
                    end
                end
            end
            if (p) begin
                mFright = FT; mTog = 0;
                if (acc) mMask = 4'h0;
            end else if (acc && frBefore) begin
                mFright--; mTog = !mTog;
                mMask = mTog ? 4'hF : 4'h0;
            end else if (acc) begin
                mMask = 4'hF;
            end
            newMode = (mFright > 0) ? 2 : (mPhase % 2);
            expFlip = p || (oldMode != 2 && newMode != 2 && newMode != oldMode);
            expMode = 2'(newMode);

            mPos    = newPos;
            expBusy = (newPos != 0);
            expQReq = (newPos % 2 == 1) && (newPos <= 7);
            if (expQReq) expQSel = 2'((newPos - 1) / 2);
        end
    endtask

    // Drives one cycle of inputs at the falling edge; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic t, input logic p,
                                 input logic [3:0] en, input logic [3:0] w);
        @(negedge clk);
        reset = rst; tick = t; powerPellet = p; ghostEnable = en; wallBits = w;
        @(posedge clk);
        modelStep(rst, t, p, en, w);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, curEn, 4'($urandom));
    endtask

    task automatic runTick(input logic p);
        applyStimulus(1'b0, 1'b1, p, curEn, 4'($urandom));
        idle(9);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("qReq",       16'(qReq),      16'(expQReq));
            checkOutput("qSel",       16'(qSel),      16'(expQSel));
            checkOutput("canMoveAll", canMoveAll,     expCan);
            checkOutput("ghostStep",  16'(ghostStep), 16'(expStep));
            checkOutput("mode",       16'(mode),      16'(expMode));
            checkOutput("modeFlip",   16'(modeFlip),  16'(expFlip));
            checkOutput("busy",       16'(busy),      16'(expBusy));
            checkOutput("overrun",    16'(overrun),   16'(expOverrun));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] wtab [4];
        wtab[0] = 4'hA; wtab[1] = 4'h5; wtab[2] = 4'hC; wtab[3] = 4'h3;
        modelReset();
        checking = 1'b1;

        // Reset values, then one sequence with a fixed wall table.
        applyStimulus(1'b1, 1'b0, 1'b0, curEn, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, curEn, 4'h0);
        checkOutput("rst_canMoveAll", canMoveAll, 16'h0000);
        checkOutput("rst_mode", 16'(mode), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, curEn, 4'h0);
        checkOutput("t1_qReq0", 16'(qReq), 16'h1);
        checkOutput("t1_busy", 16'(busy), 16'h1);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, curEn, (j % 2 == 0) ? wtab[j / 2 - 1] : 4'h0);
            if (j == 2) checkOutput("t1_qSel1", 16'(qSel), 16'h1);
        end
        checkOutput("t1_canMoveAll", canMoveAll, 16'h3C5A);
        checkOutput("t1_ghostStep", 16'(ghostStep), 16'hF);
        idle(1);
        checkOutput("t1_stepDone", 16'(ghostStep), 16'h0);
        checkOutput("t1_busyDone", 16'(busy), 16'h0);

        // Partial enable and a dropped tick inside the sequence.
        curEn = 4'b0101;
        applyStimulus(1'b0, 1'b1, 1'b0, curEn, 4'h0);
        for (int j = 1; j <= 8; j++)
            applyStimulus(1'b0, (j == 8), 1'b0, curEn, 4'($urandom));
        checkOutput("t2_ghostStep", 16'(ghostStep), 16'h5);
        checkOutput("t2_overrun", 16'(overrun), 16'h1);
        idle(2);
        curEn = 4'hF;

        // Scatter -> chase -> scatter.
        applyStimulus(1'b1, 1'b0, 1'b0, curEn, 4'h0);
        checkOutput("t3_overrunCleared", 16'(overrun), 16'h0);
        runTick(1'b0); runTick(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, curEn, 4'h0);
        checkOutput("t3_chase", 16'(mode), 16'h1);
        checkOutput("t3_flip1", 16'(modeFlip), 16'h1);
        idle(9);
        runTick(1'b0); runTick(1'b0); runTick(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, curEn, 4'h0);
        checkOutput("t3_scatter", 16'(mode), 16'h0);
        checkOutput("t3_flip2", 16'(modeFlip), 16'h1);
        idle(9);

        // Pellet during chase: half-speed steps, then resume held phase count.
        runTick(1'b0); runTick(1'b0); runTick(1'b0);
        runTick(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, curEn, 4'h0);
        checkOutput("t4_fright", 16'(mode), 16'h2);
        checkOutput("t4_flip", 16'(modeFlip), 16'h1);
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, curEn, 4'h0);
            idle(8);
            checkOutput("t4_halfStep", 16'(ghostStep), (i % 2 == 0) ? 16'hF : 16'h0);
            idle(1);
        end
        checkOutput("t4_backToChase", 16'(mode), 16'h1);
        runTick(1'b0); runTick(1'b0);
        checkOutput("t4_heldCount", 16'(mode), 16'h1);
        runTick(1'b0);
        checkOutput("t4_resumed", 16'(mode), 16'h0);

        // Pellet with tick, then a reload mid-fright.
        applyStimulus(1'b0, 1'b1, 1'b1, curEn, 4'h0);
        checkOutput("t5_fright", 16'(mode), 16'h2);
        idle(9);
        for (int i = 0; i < FT - 1; i++) runTick(1'b0);
        checkOutput("t5_stillFright", 16'(mode), 16'h2);
        runTick(1'b0);
        checkOutput("t5_exit", 16'(mode), 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, curEn, 4'h0);
        runTick(1'b0); runTick(1'b0); runTick(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, curEn, 4'h0);
        checkOutput("t5_reloadFlip", 16'(modeFlip), 16'h1);
        for (int i = 0; i < FT - 1; i++) runTick(1'b0);
        checkOutput("t5_reloaded", 16'(mode), 16'h2);
        runTick(1'b0);
        checkOutput("t5_reloadExit", 16'(mode), 16'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, curEn, 4'h0);
        idle(9);
        for (int i = 0; i < FT; i++) runTick(1'b0);
        checkOutput("t5_expiryWithPellet", 16'(mode), 16'h1);

        // Reset during CAPTURE(2).
        applyStimulus(1'b0, 1'b1, 1'b0, curEn, 4'h0);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0, curEn, 4'h0);
        checkOutput("t6_busy", 16'(busy), 16'h0);
        checkOutput("t6_canMoveAll", canMoveAll, 16'h0000);
        checkOutput("t6_qSel", 16'(qSel), 16'h0);
        idle(12);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) curEn = 4'($urandom);
            applyStimulus(($urandom_range(0, 1499) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 79) == 0),
                          curEn, 4'($urandom));
        end

        @(negedge clk);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
